// File: rtl/and_or_pkg.sv
// Op codes, FSM encoding and default width shared by the and_or unit, its issuer and the bench.
package and_or_pkg;

    localparam int DEFAULT_DATA_W = 4;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_AND  = 2'b01;
    localparam logic [1:0] OP_OR   = 2'b10;
    localparam logic [1:0] OP_BOTH = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } issuerState_t;

    function automatic logic isLegalOp(input logic [1:0] op);
        return (op == OP_AND) || (op == OP_OR);
    endfunction

endpackage

// File: rtl/and_or.sv
// The combinational and_or unit; with neither select asserted it outputs zero.
// No state, no latency, no flow control.
module and_or
    import and_or_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic [DATA_W-1:0] aIn,
    input  logic [DATA_W-1:0] bIn,
    input  logic              doAnd,
    input  logic              doOr,
    output logic [DATA_W-1:0] out,
    output logic              isAnd
);

    always_comb begin
        out = '0;
        if (doAnd) begin
            out[0] = (|aIn) && (|bIn);
        end else if (doOr) begin
            out[0] = (|aIn) || (|bIn);
        end
    end

    assign isAnd = doAnd;

endmodule

// File: rtl/and_or_expect.sv
// Combinational model of the and_or result: bit 0 is the AND/OR of "operand is non-zero".
// No state, no latency, no flow control.
module and_or_expect
    import and_or_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic [DATA_W-1:0] aIn,
    input  logic [DATA_W-1:0] bIn,
    input  logic              doAnd,
    input  logic              doOr,
    output logic [DATA_W-1:0] expOut
);

    always_comb begin
        expOut = '0;
        if (doAnd) begin
            expOut[0] = (|aIn) && (|bIn);
        end else if (doOr) begin
            expOut[0] = (|aIn) || (|bIn);
        end
    end

endmodule

// File: rtl/and_or_issuer.sv
// Sequences one command at a time into the and_or unit and returns its result; legal ops respond at N+2, illegal at N+1.
// Response is held until rspReady; no command is taken while a response is pending. AND_OR_ISSUER_CHECK_EN adds a result check.
module and_or_issuer
    import and_or_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmdValid,
    output logic              cmdReady,
    input  logic [1:0]        cmdOp,
    input  logic [DATA_W-1:0] cmdA,
    input  logic [DATA_W-1:0] cmdB,
    output logic [DATA_W-1:0] aIn,
    output logic [DATA_W-1:0] bIn,
    output logic              doAnd,
    output logic              doOr,
    input  logic [DATA_W-1:0] unitOut,
    input  logic              unitIsAnd,
    output logic              rspValid,
    input  logic              rspReady,
    output logic [DATA_W-1:0] rspData,
    output logic              rspIsAnd,
    output logic              rspErr,
    output logic [CNT_W-1:0]  opCount
);

    issuerState_t      state;
    issuerState_t      stateNxt;
    logic [DATA_W-1:0] aInNxt;
    logic [DATA_W-1:0] bInNxt;
    logic              doAndNxt;
    logic              doOrNxt;
    logic [DATA_W-1:0] rspDataNxt;
    logic              rspIsAndNxt;
    logic              rspErrNxt;
    logic [CNT_W-1:0]  opCountNxt;

`ifdef AND_OR_ISSUER_CHECK_EN
    // Fed from the held unit inputs, which equal the accepted command during ISSUE.
    logic [DATA_W-1:0] expOut;

    and_or_expect #(
        .DATA_W (DATA_W)
    ) uExpect (
        .aIn    (aIn),
        .bIn    (bIn),
        .doAnd  (doAnd),
        .doOr   (doOr),
        .expOut (expOut)
    );
`endif

    assign cmdReady = (state == IDLE);
    assign rspValid = (state == RESP);

    always_comb begin
        stateNxt    = state;
        aInNxt      = aIn;
        bInNxt      = bIn;
        doAndNxt    = doAnd;
        doOrNxt     = doOr;
        rspDataNxt  = rspData;
        rspIsAndNxt = rspIsAnd;
        rspErrNxt   = rspErr;
        opCountNxt  = opCount;

        case (state)
            IDLE: begin
                if (cmdValid) begin
                    if (isLegalOp(cmdOp)) begin
                        aInNxt   = cmdA;
                        bInNxt   = cmdB;
                        doAndNxt = (cmdOp == OP_AND);
                        doOrNxt  = (cmdOp == OP_OR);
                        stateNxt = ISSUE;
                    end else begin
                        // Illegal ops never reach the unit; answer immediately with an error.
                        rspDataNxt  = '0;
                        rspIsAndNxt = 1'b0;
                        rspErrNxt   = 1'b1;
                        stateNxt    = RESP;
                    end
                end
            end

            ISSUE: begin
                rspDataNxt  = unitOut;
                rspIsAndNxt = unitIsAnd;
                // doAnd still holds (op == AND) for the command being issued.
                rspErrNxt   = (unitIsAnd != doAnd);
`ifdef AND_OR_ISSUER_CHECK_EN
                rspErrNxt   = rspErrNxt || (unitOut != expOut);
`endif
                aInNxt      = '0;
                bInNxt      = '0;
                doAndNxt    = 1'b0;
                doOrNxt     = 1'b0;
                stateNxt    = RESP;
            end

            RESP: begin
                if (rspReady) begin
                    opCountNxt = opCount + CNT_W'(1);
                    stateNxt   = IDLE;
                end
            end

            default: begin
                stateNxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            aIn      <= '0;
            bIn      <= '0;
            doAnd    <= 1'b0;
            doOr     <= 1'b0;
            rspData  <= '0;
            rspIsAnd <= 1'b0;
            rspErr   <= 1'b0;
            opCount  <= '0;
        end else begin
            state    <= stateNxt;
            aIn      <= aInNxt;
            bIn      <= bInNxt;
            doAnd    <= doAndNxt;
            doOr     <= doOrNxt;
            rspData  <= rspDataNxt;
            rspIsAnd <= rspIsAndNxt;
            rspErr   <= rspErrNxt;
            opCount  <= opCountNxt;
        end
    end

    doSelExclusive: assert property (@(posedge clk) disable iff (rst) !(doAnd && doOr));

endmodule

// File: tb/tb_and_or_issuer.sv
// Issuer wired to a real and_or unit; directed cases then a randomized run past the opCount wrap.
module tb_and_or_issuer;
    import and_or_pkg::*;

    localparam int DW = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmdValid;
    logic          cmdReady;
    logic [1:0]    cmdOp;
    logic [DW-1:0] cmdA;
    logic [DW-1:0] cmdB;
    logic [DW-1:0] aIn;
    logic [DW-1:0] bIn;
    logic          doAnd;
    logic          doOr;
    logic [DW-1:0] auOut;
    logic          auIsAnd;
    logic [DW-1:0] unitOut;
    logic          unitIsAnd;
    logic          rspValid;
    logic          rspReady;
    logic [DW-1:0] rspData;
    logic          rspIsAnd;
    logic          rspErr;
    logic [CW-1:0] opCount;

    logic          forceOutEn;
    logic [DW-1:0] forceOutVal;
    logic          flipIsAnd;

    int checks    = 0;
    int failures  = 0;
    int modelCount = 0;

    always #5 clk = ~clk;

    and_or #(.DATA_W(DW)) uUnit (
        .aIn   (aIn),
        .bIn   (bIn),
        .doAnd (doAnd),
        .doOr  (doOr),
        .out   (auOut),
        .isAnd (auIsAnd)
    );

    assign unitOut   = forceOutEn ? forceOutVal : auOut;
    assign unitIsAnd = auIsAnd ^ flipIsAnd;

    and_or_issuer #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmdValid  (cmdValid),
        .cmdReady  (cmdReady),
        .cmdOp     (cmdOp),
        .cmdA      (cmdA),
        .cmdB      (cmdB),
        .aIn       (aIn),
        .bIn       (bIn),
        .doAnd     (doAnd),
        .doOr      (doOr),
        .unitOut   (unitOut),
        .unitIsAnd (unitIsAnd),
        .rspValid  (rspValid),
        .rspReady  (rspReady),
        .rspData   (rspData),
        .rspIsAnd  (rspIsAnd),
        .rspErr    (rspErr),
        .opCount   (opCount)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkUnitIdle(input string tag);
        checkVal({tag, ".doAnd"}, doAnd, 0);
        checkVal({tag, ".doOr"}, doOr, 0);
        checkVal({tag, ".aIn"}, aIn, 0);
        checkVal({tag, ".bIn"}, bIn, 0);
    endtask

    // inject: 0 none, 1 force unitOut=2, 2 invert unitIsAnd (both only during ISSUE)
    task automatic runCmd(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input int stall, input int inject);
        logic          legal;
        logic [DW-1:0] expData;
        logic          expIsAnd;
        logic          expErr;

        legal    = (op == 2'b01) || (op == 2'b10);
        expData  = '0;
        expIsAnd = 1'b0;
        expErr   = 1'b1;
        if (legal) begin
            expData[0] = (op == 2'b01) ? ((a != 0) && (b != 0)) : ((a != 0) || (b != 0));
            expIsAnd   = (op == 2'b01);
            expErr     = 1'b0;
            if (inject == 1) begin
                expData = DW'(2);
`ifdef AND_OR_ISSUER_CHECK_EN
                expErr  = 1'b1;
`endif
            end
            if (inject == 2) begin
                expIsAnd = ~expIsAnd;
                expErr   = 1'b1;
            end
        end

        checkVal("idle.cmdReady", cmdReady, 1);
        checkVal("idle.rspValid", rspValid, 0);
        cmdValid    = 1'b1;
        cmdOp       = op;
        cmdA        = a;
        cmdB        = b;
        forceOutEn  = legal && (inject == 1);
        forceOutVal = DW'(2);
        flipIsAnd   = legal && (inject == 2);
        tick();
        cmdValid = 1'b0;
        cmdOp    = 2'($urandom);
        cmdA     = DW'($urandom);
        cmdB     = DW'($urandom);
        checkVal("n1.cmdReady", cmdReady, 0);
        if (legal) begin
            checkVal("issue.doAnd", doAnd, op == 2'b01);
            checkVal("issue.doOr", doOr, op == 2'b10);
            checkVal("issue.aIn", aIn, a);
            checkVal("issue.bIn", bIn, b);
            checkVal("issue.rspValid", rspValid, 0);
            tick();
        end
        forceOutEn = 1'b0;
        flipIsAnd  = 1'b0;

        checkVal("resp.rspValid", rspValid, 1);
        checkVal("resp.cmdReady", cmdReady, 0);
        checkUnitIdle("resp");
        checkVal("resp.rspData", rspData, expData);
        checkVal("resp.rspIsAnd", rspIsAnd, expIsAnd);
        checkVal("resp.rspErr", rspErr, expErr);

        if (stall > 0) begin
            rspReady = 1'b0;
            cmdValid = 1'b1;
            cmdOp    = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
            cmdA     = DW'($urandom_range(1, 15));
            cmdB     = DW'($urandom_range(1, 15));
        end else begin
            rspReady = 1'b1;
        end
        for (int i = 0; i < stall; i++) begin
            tick();
            checkVal("stall.rspValid", rspValid, 1);
            checkVal("stall.cmdReady", cmdReady, 0);
            checkVal("stall.rspData", rspData, expData);
            checkVal("stall.rspIsAnd", rspIsAnd, expIsAnd);
            checkVal("stall.rspErr", rspErr, expErr);
            checkVal("stall.opCount", opCount, modelCount % 256);
            checkVal("stall.doAnd", doAnd, 0);
            checkVal("stall.doOr", doOr, 0);
        end
        rspReady = 1'b1;
        tick();
        modelCount = (modelCount + 1) % 256;
        checkVal("hs.rspValid", rspValid, 0);
        checkVal("hs.cmdReady", cmdReady, 1);
        checkVal("hs.doAnd", doAnd, 0);
        checkVal("hs.doOr", doOr, 0);
        checkVal("hs.opCount", opCount, modelCount);
        cmdValid = 1'b0;
        rspReady = 1'($urandom_range(0, 1));
    endtask

    task automatic checkAfterReset(input string tag);
        checkVal({tag, ".rspValid"}, rspValid, 0);
        checkVal({tag, ".cmdReady"}, cmdReady, 1);
        checkVal({tag, ".opCount"}, opCount, 0);
        checkUnitIdle(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] rop;
        rst         = 1'b1;
        cmdValid    = 1'b0;
        cmdOp       = 2'b00;
        cmdA        = '0;
        cmdB        = '0;
        rspReady    = 1'b0;
        forceOutEn  = 1'b0;
        forceOutVal = '0;
        flipIsAnd   = 1'b0;
        tick();
        tick();
        checkAfterReset("reset");
        checkVal("reset.rspData", rspData, 0);
        checkVal("reset.rspIsAnd", rspIsAnd, 0);
        checkVal("reset.rspErr", rspErr, 0);
        rst = 1'b0;
        tick();

        runCmd(2'b01, 4'b0011, 4'b0100, 0, 0);
        runCmd(2'b10, 4'b0000, 4'b1000, 0, 0);
        runCmd(2'b10, 4'b0000, 4'b0000, 0, 0);
        runCmd(2'b11, 4'b0101, 4'b0110, 0, 0);
        runCmd(2'b00, 4'b1111, 4'b1111, 0, 0);
        runCmd(2'b01, 4'b1111, 4'b0001, 5, 0);
        runCmd(2'b11, 4'b0001, 4'b0001, 5, 0);
        runCmd(2'b01, 4'b0011, 4'b0011, 0, 1);
        runCmd(2'b10, 4'b0001, 4'b0000, 2, 2);

        // Reset while ISSUE drives the unit.
        cmdValid = 1'b1;
        cmdOp    = 2'b01;
        cmdA     = 4'b0111;
        cmdB     = 4'b0101;
        tick();
        cmdValid = 1'b0;
        checkVal("rstIssue.doAnd", doAnd, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        modelCount = 0;
        checkAfterReset("rstIssue");

        runCmd(2'b10, 4'b0010, 4'b0000, 0, 0);

        // Reset while a response is pending.
        cmdValid = 1'b1;
        cmdOp    = 2'b10;
        cmdA     = 4'b0001;
        cmdB     = 4'b0001;
        rspReady = 1'b0;
        tick();
        cmdValid = 1'b0;
        tick();
        checkVal("rstResp.rspValid", rspValid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        modelCount = 0;
        checkAfterReset("rstResp");

        // Long random run: carries opCount through 255 -> 0.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                rop = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
            end else begin
                rop = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
            end
            runCmd(rop, DW'($urandom_range(0, 3) == 0 ? 0 : $urandom),
                   DW'($urandom_range(0, 3) == 0 ? 0 : $urandom),
                   $urandom_range(0, 2), ($urandom_range(0, 15) == 0) ? 1 : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
